// File: rtl/dmem_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_sched
// Description : Data-memory port scheduler for the dual-issue pipeline.
//               Serialises the enabled accesses of a two-slot memory bundle
//               (slot 1 older, slot 2 younger) onto one SRAM port in program
//               order. It stalls the pipeline while a second access is pending
//               and returns per-slot load data to MEM in one response cycle.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               flush              - cancels a pending second access
//               bundle_valid       - EX presents a bundle (sampled in IDLE)
//               req{1,2}_*         - per-slot enable/store/byte-sel/addr/data
//               sram_*             - single SRAM port (rdata one cycle later)
//               stallreq           - hold IF..EX while slot 2 is pending
//               resp_valid, rdata* - one-cycle response with raw read words
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        bundle_valid,
  input  logic        req1_en,
  input  logic        req2_en,
  input  logic        req1_wen,
  input  logic        req2_wen,
  input  logic [3:0]  req1_sel,
  input  logic [3:0]  req2_sel,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req2_addr,
  input  logic [31:0] req1_wdata,
  input  logic [31:0] req2_wdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t      state_q;

  // Slot-2 access held while slot 1 occupies the port.
  logic        h1_wen_q;
  logic        h2_wen_q;
  logic [3:0]  h2_sel_q;
  logic [29:0] h2_addr_q;
  logic [31:0] h2_wdata_q;
  // Slot-1 read word captured while slot 2 is on the port.
  logic [31:0] h1_rdata_q;

  // Response descriptor for the cycle after the last access of a bundle.
  logic        resp_valid_q;
  logic        resp_dual_q;
  logic        resp_ld1_q;
  logic        resp_ld2_q;

  logic        w_accept;

  // Word addresses only; the byte offset is already folded into the selects.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{req1_addr[1:0], req2_addr[1:0]};

  assign w_accept = (state_q == IDLE) && bundle_valid && !flush;

  // Port mux: issue is combinational from EX so a single access costs no cycle.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    stallreq   = 1'b0;
    if (w_accept && req1_en) begin
      sram_en    = 1'b1;
      sram_wen   = req1_wen ? req1_sel : 4'b0000;
      sram_addr  = {req1_addr[31:2], 2'b00};
      sram_wdata = req1_wdata;
      stallreq   = req2_en;
    end else if (w_accept && req2_en) begin
      sram_en    = 1'b1;
      sram_wen   = req2_wen ? req2_sel : 4'b0000;
      sram_addr  = {req2_addr[31:2], 2'b00};
      sram_wdata = req2_wdata;
    end else if ((state_q == SECOND) && !flush) begin
      sram_en    = 1'b1;
      sram_wen   = h2_wen_q ? h2_sel_q : 4'b0000;
      sram_addr  = {h2_addr_q, 2'b00};
      sram_wdata = h2_wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      h1_wen_q     <= 1'b0;
      h2_wen_q     <= 1'b0;
      h2_sel_q     <= 4'b0000;
      h2_addr_q    <= 30'h0;
      h2_wdata_q   <= 32'h0;
      h1_rdata_q   <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_dual_q  <= 1'b0;
      resp_ld1_q   <= 1'b0;
      resp_ld2_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_accept && req1_en && req2_en) begin
            h1_wen_q   <= req1_wen;
            h2_wen_q   <= req2_wen;
            h2_sel_q   <= req2_sel;
            h2_addr_q  <= req2_addr[31:2];
            h2_wdata_q <= req2_wdata;
            state_q    <= SECOND;
          end else if (w_accept && (req1_en || req2_en)) begin
            resp_valid_q <= 1'b1;
            resp_dual_q  <= 1'b0;
            resp_ld1_q   <= req1_en && !req1_wen;
            resp_ld2_q   <= req2_en && !req2_wen;
          end
        end
        SECOND: begin
          state_q <= IDLE;
          // A flush here drops slot 2 and the whole response.
          if (!flush) begin
            h1_rdata_q   <= sram_rdata;
            resp_valid_q <= 1'b1;
            resp_dual_q  <= 1'b1;
            resp_ld1_q   <= !h1_wen_q;
            resp_ld2_q   <= !h2_wen_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stores carry no data, so their slot reads back as zero.
  assign resp_valid = resp_valid_q;
  assign rdata1 = (resp_valid_q && resp_ld1_q) ?
                  (resp_dual_q ? h1_rdata_q : sram_rdata) : 32'h0;
  assign rdata2 = (resp_valid_q && resp_ld2_q) ? sram_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_sched
// Description : Directed bench for dmem_port_sched with a behavioural
//               single-port SRAM (registered read, byte-enable write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_sched;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        bundle_valid;
  logic        req1_en, req2_en, req1_wen, req2_wen;
  logic [3:0]  req1_sel, req2_sel;
  logic [31:0] req1_addr, req2_addr, req1_wdata, req2_wdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        stallreq, resp_valid;
  logic [31:0] rdata1, rdata2;

  // Memory preload port, used only while the DUT is in reset.
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  dmem_port_sched dut (
    .clk(clk), .rst(rst), .flush(flush), .bundle_valid(bundle_valid),
    .req1_en(req1_en), .req2_en(req2_en), .req1_wen(req1_wen), .req2_wen(req2_wen),
    .req1_sel(req1_sel), .req2_sel(req2_sel), .req1_addr(req1_addr), .req2_addr(req2_addr),
    .req1_wdata(req1_wdata), .req2_wdata(req2_wdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .stallreq(stallreq), .resp_valid(resp_valid), .rdata1(rdata1), .rdata2(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bundle_valid = 1'b0; flush = 1'b0;
    req1_en = 1'b0; req2_en = 1'b0; req1_wen = 1'b0; req2_wen = 1'b0;
    req1_sel = 4'h0; req2_sel = 4'h0;
    req1_addr = 32'h0; req2_addr = 32'h0; req1_wdata = 32'h0; req2_wdata = 32'h0;
  endtask

  task automatic slot1(input logic wen, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd);
    bundle_valid = 1'b1;
    req1_en = 1'b1; req1_wen = wen; req1_sel = sel; req1_addr = addr; req1_wdata = wd;
  endtask

  task automatic slot2(input logic wen, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd);
    bundle_valid = 1'b1;
    req2_en = 1'b1; req2_wen = wen; req2_sel = sel; req2_addr = addr; req2_wdata = wd;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    pre_en = 1'b0; pre_addr = 8'h0; pre_data = 32'h0;
    sram_rdata = 32'h0;
    tick();
    for (int i = 0; i < 256; i++) preload(8'(i), 32'h0);
    preload(8'h40, 32'hDEADBEEF); // 0x100
    preload(8'h04, 32'h11111111); // 0x010
    preload(8'h08, 32'h22222222); // 0x020
    pre_en = 1'b0;
    tick();

    // Reset state
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_sram_en", 32'(sram_en), 32'h0);
    chk("rst_stallreq", 32'(stallreq), 32'h0);
    rst = 1'b0;
    tick();

    // Single load on slot 2; low address bits ignored
    slot2(1'b0, 4'hF, 32'h0000_0103, 32'h0);
    #1;
    chk("s2_sram_en", 32'(sram_en), 32'h1);
    chk("s2_sram_addr", sram_addr, 32'h100);
    chk("s2_sram_wen", 32'(sram_wen), 32'h0);
    chk("s2_stallreq", 32'(stallreq), 32'h0);
    tick(); clear_in(); #1;
    chk("s2_resp_valid", 32'(resp_valid), 32'h1);
    chk("s2_rdata2", rdata2, 32'hDEADBEEF);
    chk("s2_rdata1", rdata1, 32'h0);
    tick();
    chk("s2_resp_once", 32'(resp_valid), 32'h0);

    // Dual load
    slot1(1'b0, 4'hF, 32'h10, 32'h0);
    slot2(1'b0, 4'hF, 32'h20, 32'h0);
    #1;
    chk("dl_T_stallreq", 32'(stallreq), 32'h1);
    chk("dl_T_addr", sram_addr, 32'h10);
    tick(); #1;
    chk("dl_T1_addr", sram_addr, 32'h20);
    chk("dl_T1_stallreq", 32'(stallreq), 32'h0);
    chk("dl_T1_resp_valid", 32'(resp_valid), 32'h0);
    tick(); clear_in(); #1;
    chk("dl_T2_resp_valid", 32'(resp_valid), 32'h1);
    chk("dl_T2_rdata1", rdata1, 32'h11111111);
    chk("dl_T2_rdata2", rdata2, 32'h22222222);
    tick();

    // Store byte then load same word
    slot1(1'b1, 4'b0010, 32'h40, 32'h0000AB00);
    slot2(1'b0, 4'hF, 32'h40, 32'h0);
    #1;
    chk("sl_T_wen", 32'(sram_wen), 32'h2);
    chk("sl_T_wdata", sram_wdata, 32'h0000AB00);
    tick(); #1;
    chk("sl_T1_wen", 32'(sram_wen), 32'h0);
    chk("sl_T1_addr", sram_addr, 32'h40);
    tick(); clear_in(); #1;
    chk("sl_T2_resp_valid", 32'(resp_valid), 32'h1);
    chk("sl_T2_rdata2", rdata2, 32'h0000AB00);
    chk("sl_T2_rdata1", rdata1, 32'h0);
    tick();

    // Flush in SECOND: slot-2 store to 0x80 must never land
    slot1(1'b0, 4'hF, 32'h10, 32'h0);
    slot2(1'b1, 4'hF, 32'h80, 32'hCAFEF00D);
    #1;
    chk("fl_T_stallreq", 32'(stallreq), 32'h1);
    tick(); flush = 1'b1; #1;
    chk("fl_T1_sram_en", 32'(sram_en), 32'h0);
    chk("fl_T1_stallreq", 32'(stallreq), 32'h0);
    tick(); clear_in(); #1;
    chk("fl_T2_resp_valid", 32'(resp_valid), 32'h0);
    slot1(1'b0, 4'hF, 32'h80, 32'h0);
    tick(); clear_in(); #1;
    chk("fl_mem_untouched", rdata1, 32'h0);
    tick();

    // Flush while IDLE blocks acceptance
    slot1(1'b0, 4'hF, 32'h10, 32'h0);
    flush = 1'b1;
    #1;
    chk("fi_sram_en", 32'(sram_en), 32'h0);
    tick(); clear_in(); #1;
    chk("fi_resp_valid", 32'(resp_valid), 32'h0);
    tick();

    // Back-to-back single loads with overlapping responses
    slot1(1'b0, 4'hF, 32'h10, 32'h0); #1;
    chk("bb0_sram_en", 32'(sram_en), 32'h1);
    chk("bb0_stallreq", 32'(stallreq), 32'h0);
    tick(); clear_in(); slot2(1'b0, 4'hF, 32'h20, 32'h0); #1;
    chk("bb1_sram_en", 32'(sram_en), 32'h1);
    chk("bb1_stallreq", 32'(stallreq), 32'h0);
    chk("bb1_resp_valid", 32'(resp_valid), 32'h1);
    chk("bb1_rdata1", rdata1, 32'h11111111);
    tick(); clear_in(); slot1(1'b0, 4'hF, 32'h100, 32'h0); #1;
    chk("bb2_sram_en", 32'(sram_en), 32'h1);
    chk("bb2_stallreq", 32'(stallreq), 32'h0);
    chk("bb2_resp_valid", 32'(resp_valid), 32'h1);
    chk("bb2_rdata2", rdata2, 32'h22222222);
    chk("bb2_rdata1", rdata1, 32'h0);
    tick(); clear_in(); #1;
    chk("bb3_resp_valid", 32'(resp_valid), 32'h1);
    chk("bb3_rdata1", rdata1, 32'hDEADBEEF);
    chk("bb3_rdata2", rdata2, 32'h0);
    chk("bb3_stallreq", 32'(stallreq), 32'h0);
    tick();
    chk("bb4_resp_valid", 32'(resp_valid), 32'h0);

    // Reset during SECOND
    slot1(1'b0, 4'hF, 32'h10, 32'h0);
    slot2(1'b0, 4'hF, 32'h20, 32'h0);
    #1;
    chk("rs_T_stallreq", 32'(stallreq), 32'h1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; clear_in(); #1;
    chk("rs_T2_resp_valid", 32'(resp_valid), 32'h0);
    chk("rs_T2_rdata1", rdata1, 32'h0);
    chk("rs_T2_rdata2", rdata2, 32'h0);
    chk("rs_T2_sram_en", 32'(sram_en), 32'h0);
    tick();
    chk("rs_T3_resp_valid", 32'(resp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
